// File: rtl/dsi_tx_arbiter.sv
// Shares the DSI lanes controller between the video and command packet sources.
// One source is granted at a time; the LP mode flag is framed around each packet and an idle gap follows.
module dsi_tx_arbiter #(
  parameter int GAP_CYCLES    = 4,
  parameter int MAX_CMD_BURST = 3
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [31:0] vid_data,
  input  logic [3:0]  vid_strb,
  input  logic        vid_last,
  output logic        vid_data_rqst,
  input  logic        cmd_req,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_strb,
  input  logic        cmd_last,
  output logic        cmd_data_rqst,
  input  logic        cmd_lp,
  input  logic        clock_ready,
  input  logic        lines_active,
  input  logic        iface_data_rqst,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  output logic        iface_lpm_en,
  output logic        grant_vid,
  output logic        grant_cmd,
  output logic        busy
);
  localparam int CW = $clog2(MAX_CMD_BURST + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DRAIN, S_GAP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sel, w_sel_nxt;  // 1 = command source
  logic            r_mode_lp, w_mode_lp_nxt;
  logic [CW-1:0]   r_cmd_cnt, w_cmd_cnt_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic            w_pick_vid, w_sel_last, w_xfer, w_owned;

  // Command wins ties unless it has already taken MAX_CMD_BURST grants in a row
  assign w_pick_vid = vid_req & (~cmd_req | (r_cmd_cnt == CW'(MAX_CMD_BURST)));
  assign w_sel_last = r_sel ? cmd_last : vid_last;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_mode_lp <= 1'b0;
      r_cmd_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_mode_lp <= w_mode_lp_nxt;
      r_cmd_cnt <= w_cmd_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_mode_lp_nxt = r_mode_lp;
    w_cmd_cnt_nxt = r_cmd_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (clock_ready && (vid_req || cmd_req)) begin
          w_state_nxt = S_SETUP;
          if (w_pick_vid) begin
            w_sel_nxt     = 1'b0;
            w_mode_lp_nxt = 1'b0;
            w_cmd_cnt_nxt = '0;
          end else begin
            w_sel_nxt     = 1'b1;
            w_mode_lp_nxt = cmd_lp;
            if (!vid_req)
              w_cmd_cnt_nxt = '0;
            else if (r_cmd_cnt != CW'(MAX_CMD_BURST))
              w_cmd_cnt_nxt = r_cmd_cnt + CW'(1);
          end
        end
      end
      S_SETUP: w_state_nxt = S_XFER;
      S_XFER:  if (iface_data_rqst && w_sel_last) w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!lines_active) begin
          w_gap_cnt_nxt = GW'(GAP_CYCLES - 1);
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
        else                 w_gap_cnt_nxt = r_gap_cnt - GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_xfer  = (r_state == S_XFER);
  assign w_owned = (r_state == S_SETUP) || w_xfer || (r_state == S_HOLD) || (r_state == S_DRAIN);

  assign iface_write_rqst = w_xfer;
  assign iface_write_data = w_xfer ? (r_sel ? cmd_data : vid_data) : '0;
  assign iface_write_strb = w_xfer ? (r_sel ? cmd_strb : vid_strb) : '0;
  assign iface_last_word  = w_xfer & w_sel_last & iface_data_rqst;
  assign vid_data_rqst    = w_xfer & ~r_sel & iface_data_rqst;
  assign cmd_data_rqst    = w_xfer & r_sel & iface_data_rqst;
  // LP flag brackets the transfer: set in SETUP, held through HOLD, dropped in DRAIN
  assign iface_lpm_en     = r_mode_lp & ((r_state == S_SETUP) || w_xfer || (r_state == S_HOLD));
  assign grant_vid        = w_owned & ~r_sel;
  assign grant_cmd        = w_owned & r_sel;
  assign busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_dsi_tx_arbiter.sv
// Bench for dsi_tx_arbiter: directed table, hand-written corner sequences and a random run
// checked against a packet-level model of the arbitration and timing rules.
module tb_dsi_tx_arbiter;
  localparam int GAP  = 4;
  localparam int MAXB = 3;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        vid_req = 0, vid_last = 0, cmd_req = 0, cmd_last = 0, cmd_lp = 0;
  logic [31:0] vid_data = 0, cmd_data = 0;
  logic [3:0]  vid_strb = 0, cmd_strb = 0;
  logic        clock_ready = 0, lines_active = 0, iface_data_rqst = 0;
  logic        vid_data_rqst, cmd_data_rqst, iface_write_rqst, iface_last_word, iface_lpm_en;
  logic        grant_vid, grant_cmd, busy;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;

  always #5 clk_sys = ~clk_sys;

  dsi_tx_arbiter #(.GAP_CYCLES(GAP), .MAX_CMD_BURST(MAXB)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .vid_req(vid_req), .vid_data(vid_data), .vid_strb(vid_strb), .vid_last(vid_last),
    .vid_data_rqst(vid_data_rqst),
    .cmd_req(cmd_req), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_last(cmd_last),
    .cmd_data_rqst(cmd_data_rqst), .cmd_lp(cmd_lp),
    .clock_ready(clock_ready), .lines_active(lines_active), .iface_data_rqst(iface_data_rqst),
    .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
    .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
    .iface_lpm_en(iface_lpm_en), .grant_vid(grant_vid), .grant_cmd(grant_cmd), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        lp;
  } word_t;

  typedef struct {
    logic        cr, vr, vl, idr, la;
    logic [31:0] vd;
    logic [7:0]  eo;  // {busy, grant_vid, grant_cmd, wr_rqst, lpm_en, last_word, vid_drq, cmd_drq}
    logic [31:0] ed;
    logic [3:0]  es;
  } vec_t;

  word_t vq[$], cq[$];
  int    n_tests = 0, n_fail = 0, cyc = 0;

  // packet-level model state
  int    t_dec = -1, t_last = -1, idle_from = 0, la_until = 0, cnt = 0;
  bit    m_sel, m_lp;
  int    la_hold = -1;
  bit    rnd_idr = 0, rnd_cr = 0, cr_force = 1;

  // observed edge times
  int    t_lpm_rise, t_lpm_fall, t_rqst_rise, t_lastw;
  bit    prev_lpm = 0, prev_rqst = 0, prev_busy = 0;
  bit    glog[$];
  int    setup_q[$], la_fall_q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_pkt(bit is_cmd, int len, bit lp);
    word_t w;
    for (int i = 0; i < len; i++) begin
      w.d  = $urandom;
      w.s  = 4'($urandom_range(1, 15));
      w.l  = (i == len - 1);
      w.lp = is_cmd ? lp : 1'b0;
      if (is_cmd) cq.push_back(w);
      else        vq.push_back(w);
    end
  endtask

  task automatic observe();
    if (iface_lpm_en && !prev_lpm) t_lpm_rise = cyc;
    if (!iface_lpm_en && prev_lpm) t_lpm_fall = cyc;
    if (iface_write_rqst && !prev_rqst) t_rqst_rise = cyc;
    if (iface_last_word) t_lastw = cyc;
    if (busy && !prev_busy) begin
      glog.push_back(grant_cmd);
      setup_q.push_back(cyc);
    end
    prev_lpm  = iface_lpm_en;
    prev_rqst = iface_write_rqst;
    prev_busy = busy;
  endtask

  // Expected outputs for this cycle from the arbitration and timing rules, expressed as
  // event times (decision cycle, last-word cycle, lines_active release) rather than states.
  task automatic model_check();
    bit be, gv, gc, rq, lpm, lw, vdr, cdr;
    logic [31:0] ed;
    logic [3:0]  es;
    word_t w;
    {be, gv, gc, rq, lpm, lw, vdr, cdr} = '0;
    ed = '0;
    es = '0;
    if (t_dec >= 0 && t_last >= 0 && cyc > la_until) begin
      t_dec     = -1;
      t_last    = -1;
      idle_from = la_until + GAP + 1;
    end
    if (t_dec < 0) begin
      be = (cyc < idle_from);
      if (cyc >= idle_from && clock_ready && (vid_req || cmd_req)) begin
        m_sel = !(vid_req && (!cmd_req || cnt == MAXB));
        m_lp  = m_sel ? cq[0].lp : 1'b0;
        if (!m_sel)       cnt = 0;
        else if (!vid_req) cnt = 0;
        else              cnt = (cnt < MAXB) ? cnt + 1 : MAXB;
        t_dec = cyc;
      end
    end else begin
      be = 1; gv = !m_sel; gc = m_sel;
      if (cyc == t_dec + 1) lpm = m_lp;
      else if (t_last < 0) begin
        w   = m_sel ? cq[0] : vq[0];
        rq  = 1; lpm = m_lp; ed = w.d; es = w.s;
        if (iface_data_rqst) begin
          if (m_sel) begin cdr = 1; void'(cq.pop_front()); end
          else       begin vdr = 1; void'(vq.pop_front()); end
          lw = w.l;
          if (w.l) begin
            t_last   = cyc;
            la_until = cyc + 2 + ((la_hold >= 0) ? la_hold : int'($urandom_range(0, 6)));
            la_fall_q.push_back(la_until);
          end
        end
      end else if (cyc == t_last + 1) lpm = m_lp;
    end
    chk("outs", 32'({busy, grant_vid, grant_cmd, iface_write_rqst, iface_lpm_en, iface_last_word,
                     vid_data_rqst, cmd_data_rqst}), 32'({be, gv, gc, rq, lpm, lw, vdr, cdr}));
    chk("data", iface_write_data, ed);
    chk("strb", 32'(iface_write_strb), 32'(es));
  endtask

  task automatic step(bit do_rst = 1'b0);
    @(negedge clk_sys);
    rst = do_rst;
    vid_req = (vq.size() > 0);
    cmd_req = (cq.size() > 0);
    {vid_data, vid_strb, vid_last} = '0;
    {cmd_data, cmd_strb, cmd_last, cmd_lp} = '0;
    if (vid_req) begin vid_data = vq[0].d; vid_strb = vq[0].s; vid_last = vq[0].l; end
    if (cmd_req) begin
      cmd_data = cq[0].d; cmd_strb = cq[0].s; cmd_last = cq[0].l; cmd_lp = cq[0].lp;
    end
    clock_ready     = rnd_cr ? ($urandom_range(0, 3) != 0) : cr_force;
    iface_data_rqst = do_rst ? 1'b0 : (rnd_idr ? ($urandom_range(0, 2) != 0) : 1'b1);
    lines_active    = (cyc < la_until);
    #1;
    observe();
    if (!do_rst) model_check();
    else begin
      vq.delete(); cq.delete();
      t_dec = -1; t_last = -1; cnt = 0; la_until = 0;
      idle_from = cyc + 1;
    end
    cyc++;
  endtask

  task automatic run_until_idle(int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (vq.size() == 0 && cq.size() == 0 && !busy) return;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  vec_t tbl[12];
  bit   exp_order[8];

  initial begin
    // reset, then idle state with nothing pending
    step(1'b1);
    step(1'b1);
    step();

    // clock not ready: video request must not be granted
    cr_force = 0;
    push_pkt(1'b0, 2, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("no_grant_clk", 32'({grant_vid, grant_cmd, busy}), 32'd0);
    vq.delete();
    cr_force = 1;
    step();

    // directed 3-word HS video packet
    tbl[0]  = '{1, 1, 0, 1, 0, 32'hA0A0A0A0, 8'b0000_0000, 32'h0, 4'h0};
    tbl[1]  = '{1, 1, 0, 1, 0, 32'hA0A0A0A0, 8'b1100_0000, 32'h0, 4'h0};
    tbl[2]  = '{1, 1, 0, 1, 0, 32'hA0A0A0A0, 8'b1101_0010, 32'hA0A0A0A0, 4'hF};
    tbl[3]  = '{1, 1, 0, 1, 0, 32'hB1B1B1B1, 8'b1101_0010, 32'hB1B1B1B1, 4'hF};
    tbl[4]  = '{1, 1, 1, 1, 0, 32'hC2C2C2C2, 8'b1101_0110, 32'hC2C2C2C2, 4'hF};
    tbl[5]  = '{1, 0, 0, 1, 0, 32'h0, 8'b1100_0000, 32'h0, 4'h0};
    tbl[6]  = '{1, 0, 0, 1, 0, 32'h0, 8'b1100_0000, 32'h0, 4'h0};
    for (int i = 7; i < 11; i++) tbl[i] = '{1, 0, 0, 1, 0, 32'h0, 8'b1000_0000, 32'h0, 4'h0};
    tbl[11] = '{1, 0, 0, 1, 0, 32'h0, 8'b0000_0000, 32'h0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      clock_ready = tbl[i].cr; vid_req = tbl[i].vr; vid_data = tbl[i].vd; vid_last = tbl[i].vl;
      vid_strb = 4'hF; iface_data_rqst = tbl[i].idr; lines_active = tbl[i].la;
      cmd_req = 0; cmd_data = 0; cmd_strb = 0; cmd_last = 0; cmd_lp = 0;
      #1;
      observe();
      chk($sformatf("tbl%0d_outs", i), 32'({busy, grant_vid, grant_cmd, iface_write_rqst,
          iface_lpm_en, iface_last_word, vid_data_rqst, cmd_data_rqst}), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_data", i), iface_write_data, tbl[i].ed);
      chk($sformatf("tbl%0d_strb", i), 32'(iface_write_strb), 32'(tbl[i].es));
      cyc++;
    end
    t_dec = -1; t_last = -1; cnt = 0; la_until = 0; idle_from = cyc;

    // LP command packet: mode flag framing
    la_hold = 2;
    push_pkt(1'b1, 2, 1'b1);
    run_until_idle(100);
    chk("lp_setup", 32'(t_rqst_rise - t_lpm_rise), 32'd1);
    chk("lp_hold", 32'(t_lpm_fall - t_lastw), 32'd2);

    // both sources pending continuously: burst limit alternation
    la_hold = 0;
    glog.delete();
    for (int i = 0; i < 7; i++) push_pkt(1'b1, 1, 1'b0);
    for (int i = 0; i < 3; i++) push_pkt(1'b0, 1, 1'b0);
    exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};
    run_until_idle(300);
    chk("burst_cnt", 32'(glog.size()), 32'd10);
    for (int i = 0; i < 8; i++) chk($sformatf("order%0d", i), 32'(glog[i]), 32'(exp_order[i]));

    // inter-packet gap after lines_active is held 6 cycles past HOLD
    la_hold = 6;
    setup_q.delete(); la_fall_q.delete();
    push_pkt(1'b1, 2, 1'b0);
    push_pkt(1'b1, 1, 1'b0);
    run_until_idle(200);
    chk("gap_setup", 32'(setup_q[1] - la_fall_q[0]), 32'(GAP + 2));

    // reset mid-transfer with a partially built command burst
    la_hold = -1;
    push_pkt(1'b0, 2, 1'b0);
    push_pkt(1'b1, 6, 1'b1);
    for (int i = 0; i < 20 && !iface_write_rqst; i++) step();
    chk("rst_in_xfer", 32'({iface_write_rqst, grant_cmd}), 32'b11);
    step(1'b1);
    step();
    chk("rst_outs", 32'({busy, grant_vid, grant_cmd, iface_write_rqst, iface_lpm_en,
                         iface_last_word, vid_data_rqst, cmd_data_rqst}), 32'd0);
    chk("rst_data", iface_write_data, 32'd0);
    glog.delete();
    for (int i = 0; i < 3; i++) push_pkt(1'b1, 2, 1'b0);
    push_pkt(1'b0, 1, 1'b0);
    run_until_idle(300);
    chk("post_rst_cnt", 32'(glog.size()), 32'd4);
    chk("post_rst_vid", 32'(glog[3]), 32'd0);

    // randomized traffic, handshake and lane activity
    rnd_cr = 1; rnd_idr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0 && vq.size() < 8)
        push_pkt(1'b0, $urandom_range(1, 4), 1'b0);
      if ($urandom_range(0, 9) == 0 && cq.size() < 8)
        push_pkt(1'b1, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      step();
    end
    run_until_idle(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
